spr_timing_ctrl: RTL and testbench
==================================

SPR_TIMING_CTRL -- requirements
Module: spr_timing_ctrl

Interface
REQ-001 Parameter: CNT_W, default 12, width of the pixel-pair and line counters.
REQ-002 clk  input  1  single system clock; all logic is on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 i_hs  input  1  horizontal sync, active-high, same timing as at spr_core.
REQ-005 i_vs  input  1  vertical sync, active-high.
REQ-006 i_de  input  1  data enable; one pixel pair (2 subpixel columns) per cycle while high.
REQ-007 cfg_sep  input  1  requested spr_seperate_case value.
REQ-008 cfg_bypass  input  1  requested bypass; 1 holds the core disabled.
REQ-009 cfg_wr_req  input  1  config update request; level, held until ack.
REQ-010 cfg_wr_ack  output  1  one-cycle pulse when the shadow registers load.
REQ-011 en  output  1  core enable to spr_core.
REQ-012 spr_seperate_case  output  1  shadowed cfg_sep.
REQ-013 is_first_pixel  output  1  high on the first enabled pair of each line.
REQ-014 odd_even_flag  output  1  line parity; 0 on line 0 of each frame.
REQ-015 h_cnt  output  CNT_W  index of the current pair within the line.
REQ-016 v_cnt  output  CNT_W  current line index within the frame.
REQ-017 line_len_err  output  1  sticky flag: a line length differs from line 0.

Function
REQ-018 All outputs shall be registered, with 1-cycle latency from i_de/i_vs to en, is_first_pixel, h_cnt and v_cnt.
REQ-019 The FSM shall have the states IDLE, VBLANK, LINE and HBLANK.
REQ-020 IDLE shall hold en=0 and ignore i_de until the first i_vs rising edge, then go to VBLANK.
REQ-021 In VBLANK or HBLANK, an i_de rising edge shall go to LINE; in LINE, an i_de falling edge shall go to HBLANK.
REQ-022 An i_vs rising edge in any non-IDLE state shall go to VBLANK, clear v_cnt, clear odd_even_flag and clear line_len_err.
REQ-023 An i_vs rising edge during LINE shall abort the line with no v_cnt increment and no length check.
REQ-024 On an i_de rise, h_cnt shall load 0 and is_first_pixel shall be 1 for exactly that cycle.
REQ-025 While in LINE, h_cnt shall increment by 1 per cycle and saturate at 2^CNT_W-1.
REQ-026 On an i_de fall, v_cnt shall increment (saturating) and odd_even_flag shall toggle.
REQ-027 At the end of line 0, h_cnt+1 shall be stored as ref_len.
REQ-028 At the end of each later line, h_cnt+1 != ref_len shall set line_len_err, which holds until the next i_vs rise.
REQ-029 en shall equal (state==LINE) & ~bypass_shadow; is_first_pixel shall be forced to 0 when en=0.
REQ-030 A pending cfg_wr_req shall load the shadows of cfg_sep and cfg_bypass on an i_vs rising edge only, with cfg_wr_ack pulsing high in that same cycle.
REQ-031 A cfg_wr_req first asserted in the same cycle as an i_vs rise shall be served by that edge.
REQ-032 With no request pending, the shadows shall not change.
REQ-033 i_hs shall be used only for edge alignment checks; i_de is the authoritative line qualifier.

Reset
REQ-034 While rst is high, the block shall be in state IDLE with all outputs 0, both shadows 0, ref_len 0 and all edge-detect flops 0.
REQ-035 An assertion of rst mid-line shall drop en within the same cycle (asynchronously).
REQ-036 After rst is released, the block shall wait for a fresh i_vs rising edge.

Structure
REQ-037 The FSM state enum and CNT_W default shall be defined in the shared package spr_pkg.
REQ-038 A single sub-module, spr_edge_det (registered rise/fall detection), shall be instantiated once each for i_vs and i_de.

Verification
REQ-039 Reset, one vs pulse, then 3 lines of 960 de cycles each -> en high 960 cycles per line, is_first_pixel once per line, v_cnt 0,1,2, odd_even_flag 0,1,0, line_len_err=0.
REQ-040 Line 2 of 959 cycles -> line_len_err=1 after its de fall; next vs clears it to 0.
REQ-041 cfg_wr_req with cfg_sep=1 asserted mid-frame -> spr_seperate_case stays 0 until the next vs rise, then 1 with a single-cycle cfg_wr_ack.
REQ-042 cfg_bypass=1 applied -> en=0 and is_first_pixel=0 for the whole frame, while h_cnt and v_cnt still count.
REQ-043 vs rise at h_cnt=500 -> VBLANK, v_cnt=0, no error; rst pulse mid-line -> en=0 immediately and no activity until the next vs.

Source files
------------

// File: rtl/spr_pkg.sv
// Shared definitions for the SPR timing controller.
//   SPR_CNT_W   : default width of the pixel-pair and line counters
//   spr_state_e : line-timing FSM states
package spr_pkg;

  localparam int unsigned SPR_CNT_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_LINE   = 2'd2,
    ST_HBLANK = 2'd3
  } spr_state_e;

endpackage : spr_pkg

// File: rtl/spr_edge_det.sv
// Rise/fall detector built on a registered copy of the input.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (history flop clears to 0)
//   sig_i      : input level
//   rise_c_o   : high in the cycle sig_i is 1 and was 0 last cycle
//   fall_c_o   : high in the cycle sig_i is 0 and was 1 last cycle
module spr_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic sig_q;

  // History flop: previous-cycle level of the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_c_o = sig_i & ~sig_q;
  assign fall_c_o = ~sig_i & sig_q;

endmodule : spr_edge_det

// File: rtl/spr_timing_ctrl.sv
// Line/frame timing controller for spr_core: tracks i_vs/i_de to produce the
// core enable, first-pixel strobe, line parity and pair/line counters, checks
// every line against the length of line 0, and applies configuration updates
// through shadow registers that only load on a vertical sync rising edge.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   i_hs, i_vs, i_de     : video syncs and data enable (one pixel pair per cycle)
//   cfg_sep, cfg_bypass  : requested configuration
//   cfg_wr_req / _ack    : level request, one-cycle ack when the shadows load
//   en                   : core enable
//   spr_seperate_case    : shadowed cfg_sep
//   is_first_pixel       : first enabled pair of a line
//   odd_even_flag        : line parity, 0 on line 0
//   h_cnt, v_cnt         : pair index within line, line index within frame
//   line_len_err         : sticky line-length mismatch, cleared by i_vs rise
module spr_timing_ctrl
  import spr_pkg::*;
#(
  parameter int unsigned CNT_W = SPR_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             i_de,
  input  logic             cfg_sep,
  input  logic             cfg_bypass,
  input  logic             cfg_wr_req,
  output logic             cfg_wr_ack,
  output logic             en,
  output logic             spr_seperate_case,
  output logic             is_first_pixel,
  output logic             odd_even_flag,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             line_len_err
);

  // One extra bit so a saturated line (h_cnt all ones) still measures correctly.
  localparam int unsigned     LEN_W   = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  spr_state_e       state_q;
  logic [CNT_W-1:0] h_cnt_q;
  logic [CNT_W-1:0] v_cnt_q;
  logic [LEN_W-1:0] ref_len_q;
  logic             en_q;
  logic             first_q;
  logic             odd_q;
  logic             err_q;
  logic             sep_q;
  logic             byp_q;
  logic             ack_q;

  logic [CNT_W-1:0] h_cnt_d;
  logic [CNT_W-1:0] v_cnt_d;
  logic [LEN_W-1:0] line_len_d;

  logic vs_rise;
  logic vs_fall_unused;
  logic de_rise;
  logic de_fall;

  // i_hs is only an alignment reference; i_de qualifies lines, so nothing here consumes it.
  logic hs_unused;
  assign hs_unused = i_hs;

  spr_edge_det u_vs_edge (
    .clk      (clk),
    .rst      (rst),
    .sig_i    (i_vs),
    .rise_c_o (vs_rise),
    .fall_c_o (vs_fall_unused)
  );

  spr_edge_det u_de_edge (
    .clk      (clk),
    .rst      (rst),
    .sig_i    (i_de),
    .rise_c_o (de_rise),
    .fall_c_o (de_fall)
  );

  // Saturating counter increments and the length of the line now ending.
  always_comb begin
    h_cnt_d    = (h_cnt_q == CNT_MAX) ? h_cnt_q : h_cnt_q + CNT_W'(1);
    v_cnt_d    = (v_cnt_q == CNT_MAX) ? v_cnt_q : v_cnt_q + CNT_W'(1);
    line_len_d = LEN_W'(h_cnt_q) + LEN_W'(1);
  end

  // Timing FSM with registered outputs, shadow config and length check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      ref_len_q <= '0;
      en_q      <= 1'b0;
      first_q   <= 1'b0;
      odd_q     <= 1'b0;
      err_q     <= 1'b0;
      sep_q     <= 1'b0;
      byp_q     <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      ack_q   <= 1'b0;
      first_q <= 1'b0;

      // Shadows load only on a vsync edge, including a request raised in that same cycle.
      if (vs_rise && cfg_wr_req) begin
        sep_q <= cfg_sep;
        byp_q <= cfg_bypass;
        ack_q <= 1'b1;
      end

      if (vs_rise) begin
        // New frame; a line in flight is dropped without counting or checking it.
        state_q <= ST_VBLANK;
        en_q    <= 1'b0;
        v_cnt_q <= '0;
        odd_q   <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            // Wait for the first vsync; data enable is ignored here.
          end
          ST_VBLANK, ST_HBLANK: begin
            if (de_rise) begin
              state_q <= ST_LINE;
              h_cnt_q <= '0;
              en_q    <= ~byp_q;
              first_q <= ~byp_q;
            end
          end
          ST_LINE: begin
            if (de_fall) begin
              state_q <= ST_HBLANK;
              en_q    <= 1'b0;
              v_cnt_q <= v_cnt_d;
              odd_q   <= ~odd_q;
              // Line 0 sets the reference; every later line must match it.
              if (v_cnt_q == '0) begin
                ref_len_q <= line_len_d;
              end else if (line_len_d != ref_len_q) begin
                err_q <= 1'b1;
              end
            end else begin
              h_cnt_q <= h_cnt_d;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign cfg_wr_ack        = ack_q;
  assign en                = en_q;
  assign spr_seperate_case = sep_q;
  assign is_first_pixel    = first_q;
  assign odd_even_flag     = odd_q;
  assign h_cnt             = h_cnt_q;
  assign v_cnt             = v_cnt_q;
  assign line_len_err      = err_q;

endmodule : spr_timing_ctrl

// File: tb/tb_spr_timing_ctrl.sv
// Scoreboard bench for spr_timing_ctrl. Stimulus tasks describe frames and
// lines; for every driven cycle the expected outputs one clock later are
// derived from line-level bookkeeping and queued. A monitor compares each
// queued entry against the DUT shortly after the following rising edge.
module tb_spr_timing_ctrl;

  localparam int unsigned W    = 12;
  localparam int          MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_hs = 1'b0;
  logic         i_vs = 1'b0;
  logic         i_de = 1'b0;
  logic         cfg_sep = 1'b0;
  logic         cfg_bypass = 1'b0;
  logic         cfg_wr_req = 1'b0;
  logic         cfg_wr_ack;
  logic         en;
  logic         spr_seperate_case;
  logic         is_first_pixel;
  logic         odd_even_flag;
  logic [W-1:0] h_cnt;
  logic [W-1:0] v_cnt;
  logic         line_len_err;

  spr_timing_ctrl #(.CNT_W(W)) dut (
    .clk               (clk),
    .rst               (rst),
    .i_hs              (i_hs),
    .i_vs              (i_vs),
    .i_de              (i_de),
    .cfg_sep           (cfg_sep),
    .cfg_bypass        (cfg_bypass),
    .cfg_wr_req        (cfg_wr_req),
    .cfg_wr_ack        (cfg_wr_ack),
    .en                (en),
    .spr_seperate_case (spr_seperate_case),
    .is_first_pixel    (is_first_pixel),
    .odd_even_flag     (odd_even_flag),
    .h_cnt             (h_cnt),
    .v_cnt             (v_cnt),
    .line_len_err      (line_len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         en;
    logic         first;
    logic         odd;
    logic         err;
    logic         sep;
    logic         ack;
    logic [W-1:0] h;
    logic [W-1:0] v;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference bookkeeping: frame/line level view of what the outputs must show.
  bit m_idle;
  int m_v;
  bit m_odd;
  bit m_err;
  int m_h;
  int m_ref;
  bit m_sep;
  bit m_byp;
  bit req_pend;

  function automatic obs_t cur(bit ack);
    obs_t o;
    o.en    = 1'b0;
    o.first = 1'b0;
    o.odd   = m_odd;
    o.err   = m_err;
    o.sep   = m_sep;
    o.ack   = ack;
    o.h     = W'(m_h);
    o.v     = W'(m_v);
    return o;
  endfunction

  task automatic model_reset();
    m_idle   = 1'b1;
    m_v      = 0;
    m_odd    = 1'b0;
    m_err    = 1'b0;
    m_h      = 0;
    m_ref    = 0;
    m_sep    = 1'b0;
    m_byp    = 1'b0;
    req_pend = 1'b0;
  endtask

  task automatic drive(input bit vs, input bit de, input bit req, input obs_t e);
    @(negedge clk);
    i_vs       = vs;
    i_de       = de;
    i_hs       = ~de & ~vs;
    cfg_wr_req = req;
    exp_q.push_back(e);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, req_pend, cur(1'b0));
  endtask

  // Vsync pulse (width >= 2); a pending request is served by its first cycle.
  task automatic vsync(input int width, input bit de_lvl);
    bit took;
    took = req_pend;
    if (took) begin
      m_sep = cfg_sep;
      m_byp = cfg_bypass;
    end
    m_idle = 1'b0;
    m_v    = 0;
    m_odd  = 1'b0;
    m_err  = 1'b0;
    drive(1'b1, de_lvl, took, cur(took));
    req_pend = 1'b0;
    for (int i = 1; i < width; i++) drive(1'b1, de_lvl, (i == 1) && took, cur(1'b0));
  endtask

  task automatic pixels(input int n);
    obs_t e;
    for (int k = 0; k < n; k++) begin
      e = cur(1'b0);
      if (!m_idle) begin
        e.en    = ~m_byp;
        e.first = (k == 0) && !m_byp;
        e.h     = W'((k > MAXV) ? MAXV : k);
      end
      drive(1'b0, 1'b1, req_pend, e);
    end
    if (!m_idle) m_h = (n - 1 > MAXV) ? MAXV : n - 1;
  endtask

  task automatic line(input int n, input int gap);
    pixels(n);
    if (!m_idle) begin
      if (m_v == 0) m_ref = n;
      else if (n != m_ref) m_err = 1'b1;
      if (m_v < MAXV) m_v = m_v + 1;
      m_odd = ~m_odd;
    end
    drive(1'b0, 1'b0, req_pend, cur(1'b0));
    blank(gap - 1);
  endtask

  task automatic abort_line(input int k);
    pixels(k);
    vsync(3, 1'b1);
    blank(3);
  endtask

  // Reset asserted in the middle of a line; en must drop before the next edge.
  task automatic reset_mid_line(input int k);
    pixels(k);
    @(negedge clk);
    rst        = 1'b1;
    cfg_wr_req = 1'b0;
    model_reset();
    exp_q.push_back(cur(1'b0));
    #1;
    checks++;
    if (en !== 1'b0 || is_first_pixel !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_en: en=%b first=%b, required en=0 first=0", en, is_first_pixel);
    end
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, cur(1'b0));
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(cur(1'b0));
  endtask

  // Scoreboard monitor.
  obs_t mon_e;
  obs_t mon_a;
  always @(posedge clk) begin
    cyc++;
    #1;
    if (exp_q.size() != 0) begin
      mon_e       = exp_q.pop_front();
      mon_a.en    = en;
      mon_a.first = is_first_pixel;
      mon_a.odd   = odd_even_flag;
      mon_a.err   = line_len_err;
      mon_a.sep   = spr_seperate_case;
      mon_a.ack   = cfg_wr_ack;
      mon_a.h     = h_cnt;
      mon_a.v     = v_cnt;
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL outputs cyc %0d: got en=%b first=%b odd=%b err=%b sep=%b ack=%b h=%0d v=%0d, required en=%b first=%b odd=%b err=%b sep=%b ack=%b h=%0d v=%0d",
                 cyc, mon_a.en, mon_a.first, mon_a.odd, mon_a.err, mon_a.sep, mon_a.ack, mon_a.h, mon_a.v,
                 mon_e.en, mon_e.first, mon_e.odd, mon_e.err, mon_e.sep, mon_e.ack, mon_e.h, mon_e.v);
      end
    end
  end

  int nl;
  int base;
  int len;

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, cur(1'b0));
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(cur(1'b0));

    // Lines before the first vsync are ignored.
    blank(2);
    line(20, 3);

    // Three equal lines.
    vsync(2, 1'b0);
    blank(5);
    for (int l = 0; l < 3; l++) line(960, 20);

    // Short third line raises the error; a mid-frame request waits for vsync.
    vsync(2, 1'b0);
    blank(4);
    line(960, 10);
    cfg_sep  = 1'b1;
    req_pend = 1'b1;
    line(960, 10);
    line(959, 10);
    blank(5);
    vsync(3, 1'b0);
    blank(4);

    // Bypassed frame: no enable, counters still run.
    cfg_bypass = 1'b1;
    req_pend   = 1'b1;
    vsync(2, 1'b0);
    blank(3);
    line(960, 8);
    line(960, 8);
    cfg_bypass = 1'b0;
    cfg_sep    = 1'b0;
    req_pend   = 1'b1;
    vsync(2, 1'b0);
    blank(3);

    // Vsync arriving mid-line aborts it cleanly.
    line(700, 5);
    abort_line(501);
    line(600, 5);
    line(600, 5);

    // Reset mid-line, then nothing until a fresh vsync.
    reset_mid_line(300);
    blank(3);
    line(40, 4);
    vsync(2, 1'b0);
    blank(2);
    line(30, 3);
    line(30, 3);

    // Randomized frames.
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 2) == 0) begin
        cfg_sep    = 1'($urandom_range(0, 1));
        cfg_bypass = ($urandom_range(0, 3) == 0);
        req_pend   = 1'b1;
      end else if ($urandom_range(0, 1) == 0) begin
        cfg_sep    = 1'($urandom_range(0, 1));
        cfg_bypass = 1'($urandom_range(0, 1));
      end
      vsync(int'($urandom_range(2, 4)), 1'b0);
      blank(int'($urandom_range(2, 6)));
      nl   = int'($urandom_range(2, 5));
      base = int'($urandom_range(6, 40));
      for (int l = 0; l < nl; l++) begin
        len = base;
        if ($urandom_range(0, 4) == 0) len = base + int'($urandom_range(0, 1)) * 2 - 1;
        if ($urandom_range(0, 19) == 0) begin
          abort_line(int'($urandom_range(1, 6)));
        end else begin
          if (l == 1 && $urandom_range(0, 3) == 0) begin
            cfg_sep  = ~cfg_sep;
            req_pend = 1'b1;
          end
          line(len, int'($urandom_range(1, 6)));
        end
      end
    end

    blank(4);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_spr_timing_ctrl
